sddr_init_sequencer: RTL and testbench

Power-up and re-initialisation sequencer for the DDR3 PHY. Owns the PHY-reset and DDR-reset controls that gate the ODDR/OBUFDS clock output and RESET#, drives CKE, and issues the JEDEC mode-register and ZQ-calibration commands through a valid/ready command port. When the sequence completes it raises `init_done_o`, and the command port passes to the normal controller scheduler.

---
 rtl/sddr_pkg.sv | 54 +++++
 rtl/sddr_init_sequencer_wait_counter.sv | 23 ++
 rtl/sddr_init_sequencer.sv | 167 ++++++++++++++++
 tb/tb_sddr_init_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sddr_pkg.sv
// Shared types and constants for the DDR3 power-up / re-init sequencer.
package sddr_pkg;

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned BA_W   = 3;
    localparam int unsigned ADDR_W = 14;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_MRS  = 2'd1,
        CMD_ZQCL = 2'd2
    } sddr_cmd_e;

    typedef enum logic [3:0] {
        S_CLK_START = 4'd0,
        S_RESET     = 4'd1,
        S_WAIT_CKE  = 4'd2,
        S_TXPR      = 4'd3,
        S_MRS       = 4'd4,
        S_TMRD      = 4'd5,
        S_TMOD      = 4'd6,
        S_ZQCL      = 4'd7,
        S_TZQ       = 4'd8,
        S_DONE      = 4'd9
    } sddr_init_state_e;

    localparam logic [BA_W-1:0] MR0_BA = 3'd0;
    localparam logic [BA_W-1:0] MR1_BA = 3'd1;
    localparam logic [BA_W-1:0] MR2_BA = 3'd2;
    localparam logic [BA_W-1:0] MR3_BA = 3'd3;

    localparam logic [ADDR_W-1:0] ZQCL_A10 = 14'h0400;

    typedef struct packed {
        sddr_cmd_e         op;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
    } sddr_cmd_t;

    localparam sddr_cmd_t CMD_IDLE = '{op: CMD_NOP, ba: '0, addr: '0};

    // JEDEC issue order is MR2, MR3, MR1, MR0
    function automatic logic [BA_W-1:0] mrs_bank(input logic [1:0] step);
        logic [BA_W-1:0] ba;
        case (step)
            2'd0:    ba = MR2_BA;
            2'd1:    ba = MR3_BA;
            2'd2:    ba = MR1_BA;
            default: ba = MR0_BA;
        endcase
        return ba;
    endfunction

endpackage

// File: rtl/sddr_init_sequencer_wait_counter.sv
// Loadable down-counter shared by every dwell state of the init sequencer.
module sddr_wait_counter
    import sddr_pkg::*;
(
    input  logic             clk_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            r_count <= value_i;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign zero_o = (r_count == '0);

endmodule

// File: rtl/sddr_init_sequencer.sv
// DDR3 power-up / re-initialisation sequencer: PHY/DDR resets, CKE, MRS and ZQCL
// command issue over a valid/ready port, then hands off with init_done_o.
module sddr_init_sequencer
    import sddr_pkg::*;
#(
    parameter int unsigned RESET_CYCLES      = 80000,
    parameter int unsigned CLK_STABLE_CYCLES = 16,
    parameter int unsigned CKE_WAIT_CYCLES   = 200000,
    parameter int unsigned TXPR_CYCLES       = 64,
    parameter int unsigned TMRD_CYCLES       = 4,
    parameter int unsigned TMOD_CYCLES       = 12,
    parameter int unsigned TZQINIT_CYCLES    = 512,
    parameter logic [13:0] MR0_VAL           = 14'h0,
    parameter logic [13:0] MR1_VAL           = 14'h0,
    parameter logic [13:0] MR2_VAL           = 14'h0,
    parameter logic [13:0] MR3_VAL           = 14'h0
) (
    input  logic        in_ddr_clock_i,
    input  logic        in_ddr_reset_p_i,
    input  logic        reinit_i,
    output logic        phy_reset_p_o,
    output logic        ddr_reset_p_o,
    output logic        cke_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [1:0]  cmd_op_o,
    output logic [2:0]  cmd_ba_o,
    output logic [13:0] cmd_addr_o,
    output logic        init_done_o,
    output logic        busy_o
);

    localparam int unsigned CNT_LIMIT = 1 << CNT_W;

    // Gap states count from the command cycle, so they need at least two cycles
    if (RESET_CYCLES == 0 || CLK_STABLE_CYCLES == 0 || CKE_WAIT_CYCLES == 0 ||
        TXPR_CYCLES == 0 || TZQINIT_CYCLES == 0 || TMRD_CYCLES < 2 || TMOD_CYCLES < 2 ||
        RESET_CYCLES >= CNT_LIMIT || CLK_STABLE_CYCLES >= CNT_LIMIT ||
        CKE_WAIT_CYCLES >= CNT_LIMIT || TXPR_CYCLES >= CNT_LIMIT ||
        TMRD_CYCLES >= CNT_LIMIT || TMOD_CYCLES >= CNT_LIMIT ||
        TZQINIT_CYCLES >= CNT_LIMIT) begin : g_bad_cycles
        $error("sddr_init_sequencer: cycle parameter out of range");
    end

    sddr_init_state_e r_state, w_next;
    logic [1:0]       r_step, w_step_d;
    logic             r_phy_rst, r_ddr_rst, r_cke, r_cmd_valid, r_done, r_busy;
    sddr_cmd_t        r_cmd, w_cmd_d;
    logic             w_phy_d, w_ddr_d, w_cke_d, w_valid_d, w_done_d, w_busy_d;
    logic             w_accept, w_cnt_zero, w_cnt_load;
    logic [CNT_W-1:0] w_load_val, w_cnt_val;

    function automatic logic [ADDR_W-1:0] mrs_payload(input logic [1:0] step);
        logic [ADDR_W-1:0] val;
        case (step)
            2'd0:    val = MR2_VAL;
            2'd1:    val = MR3_VAL;
            2'd2:    val = MR1_VAL;
            default: val = MR0_VAL;
        endcase
        return val;
    endfunction

    // CLK_START loads N (not N-1): its first cycle still shows the reset values
    assign w_cnt_load = in_ddr_reset_p_i || (w_next != r_state);
    assign w_cnt_val  = in_ddr_reset_p_i ? CNT_W'(CLK_STABLE_CYCLES) : w_load_val;

    sddr_wait_counter u_wait (
        .clk_i   (in_ddr_clock_i),
        .load_i  (w_cnt_load),
        .value_i (w_cnt_val),
        .zero_o  (w_cnt_zero)
    );

    always_ff @(posedge in_ddr_clock_i) begin
        if (in_ddr_reset_p_i) begin
            r_state     <= S_CLK_START;
            r_step      <= '0;
            r_phy_rst   <= 1'b1;
            r_ddr_rst   <= 1'b1;
            r_cke       <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= CMD_IDLE;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_step      <= w_step_d;
            r_phy_rst   <= w_phy_d;
            r_ddr_rst   <= w_ddr_d;
            r_cke       <= w_cke_d;
            r_cmd_valid <= w_valid_d;
            r_cmd       <= w_cmd_d;
            r_done      <= w_done_d;
            r_busy      <= w_busy_d;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load_val = '0;
        w_step_d   = '0;
        w_cmd_d    = CMD_IDLE;
        w_valid_d  = 1'b0;
        w_accept   = r_cmd_valid && cmd_ready_i;

        case (r_state)
            S_CLK_START: if (w_cnt_zero) w_next = S_RESET;
            S_RESET:     if (w_cnt_zero) w_next = S_WAIT_CKE;
            S_WAIT_CKE:  if (w_cnt_zero) w_next = S_TXPR;
            S_TXPR:      if (w_cnt_zero) w_next = S_MRS;
            S_MRS:       if (w_accept)   w_next = (r_step == 2'd3) ? S_TMOD : S_TMRD;
            S_TMRD:      if (w_cnt_zero) w_next = S_MRS;
            S_TMOD:      if (w_cnt_zero) w_next = S_ZQCL;
            S_ZQCL:      if (w_accept)   w_next = S_TZQ;
            S_TZQ:       if (w_cnt_zero) w_next = S_DONE;
            S_DONE:      if (reinit_i)   w_next = S_CLK_START;
            default:                     w_next = S_CLK_START;
        endcase

        case (w_next)
            S_CLK_START: w_load_val = CNT_W'(CLK_STABLE_CYCLES);
            S_RESET:     w_load_val = CNT_W'(RESET_CYCLES - 1);
            S_WAIT_CKE:  w_load_val = CNT_W'(CKE_WAIT_CYCLES - 1);
            S_TXPR:      w_load_val = CNT_W'(TXPR_CYCLES - 1);
            S_TMRD:      w_load_val = CNT_W'(TMRD_CYCLES - 2);
            S_TMOD:      w_load_val = CNT_W'(TMOD_CYCLES - 2);
            S_TZQ:       w_load_val = CNT_W'(TZQINIT_CYCLES - 1);
            default:     w_load_val = '0;
        endcase

        // MR step advances on acceptance and survives the tMRD gap
        if (r_state == S_MRS) begin
            w_step_d = w_accept ? r_step + 2'd1 : r_step;
        end else if (r_state == S_TMRD) begin
            w_step_d = r_step;
        end

        if (w_next == S_MRS) begin
            w_valid_d    = 1'b1;
            w_cmd_d.op   = CMD_MRS;
            w_cmd_d.ba   = mrs_bank(w_step_d);
            w_cmd_d.addr = mrs_payload(w_step_d);
        end else if (w_next == S_ZQCL) begin
            w_valid_d    = 1'b1;
            w_cmd_d.op   = CMD_ZQCL;
            w_cmd_d.addr = ZQCL_A10;
        end

        w_phy_d  = (w_next == S_CLK_START) && (r_state != S_CLK_START);
        w_ddr_d  = (w_next == S_CLK_START) || (w_next == S_RESET);
        w_cke_d  = !(w_next inside {S_CLK_START, S_RESET, S_WAIT_CKE});
        w_done_d = (w_next == S_DONE);
        w_busy_d = (w_next != S_DONE);
    end

    assign phy_reset_p_o = r_phy_rst;
    assign ddr_reset_p_o = r_ddr_rst;
    assign cke_o         = r_cke;
    assign cmd_valid_o   = r_cmd_valid;
    assign cmd_op_o      = r_cmd.op;
    assign cmd_ba_o      = r_cmd.ba;
    assign cmd_addr_o    = r_cmd.addr;
    assign init_done_o   = r_done;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_sddr_init_sequencer.sv
// Cycle-exact checks of the init sequencer against hand-computed segment tables.
module tb_sddr_init_sequencer;

    localparam logic [13:0] MR0 = 14'h0120;
    localparam logic [13:0] MR1 = 14'h0044;
    localparam logic [13:0] MR2 = 14'h0008;
    localparam logic [13:0] MR3 = 14'h0000;

    typedef struct packed {
        logic        phy;
        logic        ddr;
        logic        cke;
        logic        valid;
        logic [1:0]  op;
        logic [2:0]  ba;
        logic [13:0] addr;
        logic        done;
        logic        busy;
    } out_t;

    typedef struct {
        int    first;
        int    last;
        out_t  exp;
        string name;
    } seg_t;

    localparam out_t E_RST  = '{phy: 1'b1, ddr: 1'b1, cke: 1'b0, valid: 1'b0, op: 2'd0, ba: 3'd0, addr: 14'h0, done: 1'b0, busy: 1'b1};
    localparam out_t E_CLK  = '{phy: 1'b0, ddr: 1'b1, cke: 1'b0, valid: 1'b0, op: 2'd0, ba: 3'd0, addr: 14'h0, done: 1'b0, busy: 1'b1};
    localparam out_t E_WCK  = '{phy: 1'b0, ddr: 1'b0, cke: 1'b0, valid: 1'b0, op: 2'd0, ba: 3'd0, addr: 14'h0, done: 1'b0, busy: 1'b1};
    localparam out_t E_WAIT = '{phy: 1'b0, ddr: 1'b0, cke: 1'b1, valid: 1'b0, op: 2'd0, ba: 3'd0, addr: 14'h0, done: 1'b0, busy: 1'b1};
    localparam out_t E_ZQ   = '{phy: 1'b0, ddr: 1'b0, cke: 1'b1, valid: 1'b1, op: 2'd2, ba: 3'd0, addr: 14'h0400, done: 1'b0, busy: 1'b1};
    localparam out_t E_DONE = '{phy: 1'b0, ddr: 1'b0, cke: 1'b1, valid: 1'b0, op: 2'd0, ba: 3'd0, addr: 14'h0, done: 1'b1, busy: 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reinit = 1'b0;
    logic        rdy = 1'b1;
    logic        phy_reset_p_o, ddr_reset_p_o, cke_o, cmd_valid_o, init_done_o, busy_o;
    logic [1:0]  cmd_op_o;
    logic [2:0]  cmd_ba_o;
    logic [13:0] cmd_addr_o;

    int    cyc, n_vec, n_bad;
    int    rst_at, reinit_at, lo_first, lo_last;
    string tname;
    seg_t  seg_q[$];

    always #5 clk = ~clk;

    sddr_init_sequencer #(
        .RESET_CYCLES      (5),
        .CLK_STABLE_CYCLES (2),
        .CKE_WAIT_CYCLES   (6),
        .TXPR_CYCLES       (3),
        .TMRD_CYCLES       (4),
        .TMOD_CYCLES       (12),
        .TZQINIT_CYCLES    (8),
        .MR0_VAL           (MR0),
        .MR1_VAL           (MR1),
        .MR2_VAL           (MR2),
        .MR3_VAL           (MR3)
    ) dut (
        .in_ddr_clock_i   (clk),
        .in_ddr_reset_p_i (rst),
        .reinit_i         (reinit),
        .phy_reset_p_o    (phy_reset_p_o),
        .ddr_reset_p_o    (ddr_reset_p_o),
        .cke_o            (cke_o),
        .cmd_valid_o      (cmd_valid_o),
        .cmd_ready_i      (rdy),
        .cmd_op_o         (cmd_op_o),
        .cmd_ba_o         (cmd_ba_o),
        .cmd_addr_o       (cmd_addr_o),
        .init_done_o      (init_done_o),
        .busy_o           (busy_o)
    );

    function automatic out_t e_mrs(input logic [2:0] ba, input logic [13:0] addr);
        out_t o;
        o       = E_WAIT;
        o.valid = 1'b1;
        o.op    = 2'd1;
        o.ba    = ba;
        o.addr  = addr;
        return o;
    endfunction

    task automatic push(input int f, input int l, input out_t e, input string n);
        seg_t s;
        s.first = f;
        s.last  = l;
        s.exp   = e;
        s.name  = n;
        seg_q.push_back(s);
    endtask

    // Full sequence from reset release at cycle b; s = extra stall cycles on MR3
    task automatic push_powerup(input int b, input int s, input int done_last);
        int e;
        e = b + s;
        push(b,      b,      E_RST,             "rst_vals");
        push(b + 1,  b + 7,  E_CLK,             "clk_start_reset");
        push(b + 8,  b + 13, E_WCK,             "wait_cke");
        push(b + 14, b + 16, E_WAIT,            "txpr");
        push(b + 17, b + 17, e_mrs(3'd2, MR2),  "mr2");
        push(b + 18, b + 20, E_WAIT,            "tmrd_a");
        push(b + 21, e + 21, e_mrs(3'd3, MR3),  "mr3");
        push(e + 22, e + 24, E_WAIT,            "tmrd_b");
        push(e + 25, e + 25, e_mrs(3'd1, MR1),  "mr1");
        push(e + 26, e + 28, E_WAIT,            "tmrd_c");
        push(e + 29, e + 29, e_mrs(3'd0, MR0),  "mr0");
        push(e + 30, e + 40, E_WAIT,            "tmod");
        push(e + 41, e + 41, E_ZQ,              "zqcl");
        push(e + 42, e + 49, E_WAIT,            "tzq");
        push(e + 50, done_last, E_DONE,         "done");
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rst    = (cyc == rst_at);
        reinit = (cyc == reinit_at);
        rdy    = !(cyc >= lo_first && cyc <= lo_last);
    endtask

    task automatic start(input string n);
        tname     = n;
        rst_at    = -1;
        reinit_at = -1;
        lo_first  = -1;
        lo_last   = -2;
        rst       = 1'b1;
        reinit    = 1'b0;
        rdy       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check(input out_t exp, input string n);
        out_t got;
        got.phy   = phy_reset_p_o;
        got.ddr   = ddr_reset_p_o;
        got.cke   = cke_o;
        got.valid = cmd_valid_o;
        got.op    = cmd_op_o;
        got.ba    = cmd_ba_o;
        got.addr  = cmd_addr_o;
        got.done  = init_done_o;
        got.busy  = busy_o;
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s/%s cyc=%0d got=%h want=%h", tname, n, cyc, got, exp);
        end
    endtask

    task automatic play();
        foreach (seg_q[i]) begin
            for (int c = seg_q[i].first; c <= seg_q[i].last; c++) begin
                while (cyc < c) tick();
                check(seg_q[i].exp, seg_q[i].name);
            end
        end
        seg_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_bad = 0;

        start("powerup");
        push_powerup(0, 0, 53);
        play();

        start("mr3_stall");
        lo_first = 21;
        lo_last  = 27;
        push_powerup(0, 7, 60);
        play();

        // Reset lands with cmd_ready_i high while MR1 is still pending
        start("reset_mr1");
        lo_first = 25;
        lo_last  = 25;
        rst_at   = 26;
        push(0,  0,  E_RST,            "rst_vals");
        push(1,  7,  E_CLK,            "clk_start_reset");
        push(8,  13, E_WCK,            "wait_cke");
        push(14, 16, E_WAIT,           "txpr");
        push(17, 17, e_mrs(3'd2, MR2), "mr2");
        push(18, 20, E_WAIT,           "tmrd_a");
        push(21, 21, e_mrs(3'd3, MR3), "mr3");
        push(22, 24, E_WAIT,           "tmrd_b");
        push(25, 26, e_mrs(3'd1, MR1), "mr1_pending");
        push_powerup(27, 0, 80);
        play();

        start("reinit_done");
        reinit_at = 52;
        push_powerup(0, 0, 52);
        push_powerup(53, 0, 106);
        play();

        start("reinit_txpr");
        reinit_at = 15;
        push_powerup(0, 0, 53);
        play();

        start("reset_reinit");
        rst_at    = 52;
        reinit_at = 52;
        push_powerup(0, 0, 52);
        push_powerup(53, 0, 106);
        play();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
